pipe_stage_hs: RTL

PIPE_STAGE_HS -- requirements
Module: pipe_stage_hs

---
 rtl/pipe_stage_hs.sv | 100 ++++++++++
 1 files changed

// File: rtl/pipe_stage_hs.sv
// Multi-stage valid/ready pipeline register with bubble collapse, flush and clock enable.
// Stage 0 faces upstream; stage DEPTH-1 drives the outputs.
module pipe_stage_hs #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 3,
   parameter int unsigned DEPTH  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clk_en,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   input  logic [CTRL_W-1:0] i_ctrl,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [2:0]        o_count
);

   logic [DEPTH-1:0]  r_v;
   logic [DEPTH-1:0]  w_v_d;
   logic [DEPTH-1:0]  w_adv;
   logic [DATA_W-1:0] r_data   [DEPTH];
   logic [DATA_W-1:0] w_data_d [DEPTH];
   logic [CTRL_W-1:0] r_ctrl   [DEPTH];
   logic [CTRL_W-1:0] w_ctrl_d [DEPTH];
   logic [2:0]        r_count;
   logic [2:0]        w_count_d;

   // Stage k may advance if downstream accepts or any stage at or after k is empty.
   always_comb begin
      w_adv = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_adv[k] = i_clk_en && (i_ready || (((~r_v) >> k) != '0));
      end
   end

   always_comb begin
      w_v_d = r_v;
      for (int k = 0; k < DEPTH; k++) begin
         w_data_d[k] = r_data[k];
         w_ctrl_d[k] = r_ctrl[k];
      end
      if (w_adv[0]) begin
         w_v_d[0]    = i_valid;
         w_data_d[0] = i_data;
         w_ctrl_d[0] = i_ctrl;
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (w_adv[k]) begin
            w_v_d[k]    = r_v[k-1];
            w_data_d[k] = r_data[k-1];
            w_ctrl_d[k] = r_ctrl[k-1];
         end
      end
      // Flush kills entries and control but leaves payload registers untouched.
      if (i_flush) begin
         w_v_d = '0;
         for (int k = 0; k < DEPTH; k++) begin
            w_data_d[k] = r_data[k];
            w_ctrl_d[k] = '0;
         end
      end
   end

   always_comb begin
      w_count_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_count_d = w_count_d + 3'(w_v_d[k]);
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v     <= '0;
         r_count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= '0;
            r_ctrl[k] <= '0;
         end
      end else begin
         r_v     <= w_v_d;
         r_count <= w_count_d;
         for (int k = 0; k < DEPTH; k++) begin
            r_data[k] <= w_data_d[k];
            r_ctrl[k] <= w_ctrl_d[k];
         end
      end
   end

   assign o_ready = w_adv[0] && !i_flush;
   assign o_valid = r_v[DEPTH-1];
   assign o_data  = r_data[DEPTH-1];
   assign o_ctrl  = r_v[DEPTH-1] ? r_ctrl[DEPTH-1] : '0;
   assign o_count = r_count;

endmodule
